co_su_seq: RTL and testbench
============================

Name: co_su_seq

Overview:
- Sequential, parametrised Cohen-Sutherland line clipper.
- Takes one 2D line segment and a runtime-programmable clip rectangle. Iteratively clips the segment against the rectangle using a multi-cycle divider, then returns the clipped endpoints with an accept or reject verdict.
- Sits between the projection stage and the rasteriser. Uses valid/ready handshakes on both sides.

Parameters:
- COORD_W, 16, signed width of every coordinate (two's complement).
- MAX_ITER, 4, maximum clip passes before a forced reject.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input line valid
- in_ready  out  1  block can accept a line
- x0_in, y0_in, x1_in, y1_in  in  COORD_W each  signed endpoint coordinates
- xmin, ymin, xmax, ymax  in  COORD_W each  signed clip rectangle, inclusive; sampled on input handshake
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- x0_out, y0_out, x1_out, y1_out  out  COORD_W each  clipped endpoints
- accept  out  1  segment (partly) visible; meaningful when out_valid=1
- reject  out  1  segment invisible; exactly one of accept/reject is high when out_valid=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, accept=0, reject=0, all coordinate outputs=0, iteration counter=0.
- rst asserted in any state, including mid-divide: on the next edge everything returns to the reset values. The partial result is discarded; no out_valid pulse.
- Outcode bits: TOP=4'b1000 (y>ymax), BOTTOM=4'b0100 (y<ymin), RIGHT=4'b0010 (x>xmax), LEFT=4'b0001 (x<xmin). All comparisons are signed.
- State machine:
  - IDLE: in_ready=1. On in_valid&in_ready, register endpoints and rectangle, clear iteration counter, go to OUTCODE.
  - OUTCODE (1 cycle): compute oc0 and oc1 from the current endpoints.
    - oc0|oc1==0 -> DONE with accept=1.
    - (oc0&oc1)!=0 -> DONE with reject=1.
    - iteration counter==MAX_ITER -> DONE with reject=1.
    - Otherwise pick ocOut = (oc0!=0) ? oc0 : oc1 and go to CALC.
  - CALC (1 cycle): select the edge by priority TOP > BOTTOM > RIGHT > LEFT within ocOut.
    - TOP/BOTTOM: num=(x1-x0)*(E-y0), den=(y1-y0), where E=ymax or ymin.
    - RIGHT/LEFT: num=(y1-y0)*(E-x0), den=(x1-x0), where E=xmax or xmin.
    - Differences are COORD_W+1 bits; the product is 2*COORD_W+2 bits, signed.
    - Load the divider with magnitudes and record the quotient sign.
  - DIV (exactly 2*COORD_W+2 cycles): restoring unsigned division, one quotient bit per cycle. Quotient truncates toward zero; the sign is reapplied after the last bit.
    - den is never zero here: exactly one endpoint lies beyond the chosen edge, so the two coordinates differ.
  - UPDATE (1 cycle):
    - Intersection point: for TOP/BOTTOM it is (x0+q, E); for RIGHT/LEFT it is (E, y0+q). Truncate to COORD_W.
    - If ocOut==oc0, replace endpoint 0 with it; otherwise replace endpoint 1.
    - Increment the iteration counter and go to OUTCODE.
  - DONE: out_valid=1. Outputs hold the current endpoints and verdict, stable while out_ready=0. On out_ready=1, go to IDLE.
- in_ready=1 only in IDLE. No overlap between lines.
- Latency:
  - Trivial accept/reject: out_valid is asserted 2 cycles after the input handshake edge.
  - Each clip pass adds 2*COORD_W+5 cycles.
- A rejected result still presents the last endpoints on the output ports; downstream ignores them.
- Inputs change while busy: no effect; rectangle and endpoints are held in registers.
- Endpoints lying exactly on an edge are inside (inclusive bounds).

Test Plan:
All scenarios use COORD_W=16, rectangle (0,0)-(639,479).
- Inside: (10,10)-(100,200) -> accept=1, outputs unchanged, out_valid 2 cycles after handshake.
- Trivial reject: (-50,10)-(-5,300), both LEFT -> reject=1, out_valid 2 cycles after handshake.
- Single right clip: (100,100)-(700,100) -> accept, (100,100)-(639,100), out_valid after 2+37 cycles.
- Two-pass diagonal: (-100,-100)-(700,700).
  - Pass 1: p0 clipped on BOTTOM to (0,0).
  - Pass 2: p1 clipped on TOP to (479,479).
  - Result: accept=1.
- Negative truncation: (-7,3)-(9,10) against rectangle (0,0)-(639,479) -> LEFT pass gives y=3+(7*7)/16=3+3=6. Output (0,6)-(9,10), accept.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
  - Assert rst during DIV -> next cycle out_valid=0, in_ready=1.
  - A following inside line completes correctly.

Source files
------------

// File: rtl/co_su_seq.sv
// co_su_seq: sequential Cohen-Sutherland line clipper.
//
// Clips one 2D segment against an inclusive, runtime-programmable rectangle.
// Each clip pass computes one edge intersection with a restoring divider that
// produces one quotient bit per cycle.
//
// Handshakes on both sides use the same rule. A transfer happens on a rising
// clk edge where valid and ready are both high. A producer holding valid=1
// keeps its data stable until that edge.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           input line handshake (in_ready only in IDLE)
//   x0_in, y0_in, x1_in, y1_in    signed endpoints, captured on the handshake
//   xmin, ymin, xmax, ymax        signed inclusive rectangle, captured on the handshake
//   out_valid / out_ready         result handshake
//   x0_out, y0_out, x1_out, y1_out clipped endpoints (last endpoints if rejected)
//   accept / reject               verdict, exactly one high while out_valid=1
//   dbg_state                     current FSM state, for observation only
module co_su_seq #(
  parameter int COORD_W  = 16,
  parameter int MAX_ITER = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x0_in,
  input  logic [COORD_W-1:0] y0_in,
  input  logic [COORD_W-1:0] x1_in,
  input  logic [COORD_W-1:0] y1_in,
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymax,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] x0_out,
  output logic [COORD_W-1:0] y0_out,
  output logic [COORD_W-1:0] x1_out,
  output logic [COORD_W-1:0] y1_out,
  output logic               accept,
  output logic               reject,
  output logic [2:0]         dbg_state
);

  localparam int N   = 2*COORD_W + 2;         // dividend / quotient width
  localparam int DCW = $clog2(N);
  localparam int IW  = $clog2(MAX_ITER + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OUTCODE = 3'd1;
  localparam logic [2:0] S_CALC    = 3'd2;
  localparam logic [2:0] S_DIV     = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0] state;
  logic signed [COORD_W-1:0] x0, y0, x1, y1;
  logic signed [COORD_W-1:0] r_xmin, r_ymin, r_xmax, r_ymax;
  logic [IW-1:0]  iter;
  logic [3:0]     oc_out;
  logic           use_p0;
  logic           verdict_acc;
  logic           is_y_r;
  logic signed [COORD_W-1:0] e_r;
  logic [N-1:0]   quo;
  logic [COORD_W+1:0] rem;
  logic [COORD_W:0]   den_r;
  logic           q_neg;
  logic [DCW-1:0] div_cnt;

  function automatic logic [3:0] outcode(
    input logic signed [COORD_W-1:0] x, y, xl, yl, xh, yh);
    outcode = {y > yh, y < yl, x > xh, x < xl};
  endfunction

  logic [3:0] oc0, oc1;
  assign oc0 = outcode(x0, y0, r_xmin, r_ymin, r_xmax, r_ymax);
  assign oc1 = outcode(x1, y1, r_xmin, r_ymin, r_xmax, r_ymax);

  // Edge selection and intersection numerator/denominator for CALC.
  logic                       is_y;
  logic signed [COORD_W-1:0]  e_sel;
  logic signed [COORD_W:0]    dx, dy, de, fa, den;
  logic signed [N-1:0]        ma, mb, num;
  logic [N-1:0]               num_mag;
  logic [COORD_W:0]           den_mag;

  always_comb begin
    is_y = oc_out[3] | oc_out[2];
    if (oc_out[3])      e_sel = r_ymax;
    else if (oc_out[2]) e_sel = r_ymin;
    else if (oc_out[1]) e_sel = r_xmax;
    else                e_sel = r_xmin;
    dx  = {x1[COORD_W-1], x1} - {x0[COORD_W-1], x0};
    dy  = {y1[COORD_W-1], y1} - {y0[COORD_W-1], y0};
    de  = is_y ? ({e_sel[COORD_W-1], e_sel} - {y0[COORD_W-1], y0})
               : ({e_sel[COORD_W-1], e_sel} - {x0[COORD_W-1], x0});
    fa  = is_y ? dx : dy;
    den = is_y ? dy : dx;
    ma  = {{(N-COORD_W-1){fa[COORD_W]}}, fa};
    mb  = {{(N-COORD_W-1){de[COORD_W]}}, de};
    num = ma * mb;
    num_mag = num[N-1] ? -num : num;
    den_mag = den[COORD_W] ? -den : den;
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  logic [COORD_W+1:0] rem_sh;
  logic               fits;
  assign rem_sh = {rem[COORD_W:0], quo[N-1]};
  assign fits   = rem_sh >= {1'b0, den_r};

  // Intersection point; only the low COORD_W quotient bits survive truncation.
  logic [COORD_W-1:0] qt, nx, ny;
  always_comb begin
    qt = q_neg ? -quo[COORD_W-1:0] : quo[COORD_W-1:0];
    nx = is_y_r ? (x0 + qt) : e_r;
    ny = is_y_r ? e_r : (y0 + qt);
  end

  assign in_ready  = (state == S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      out_valid <= 1'b0; accept <= 1'b0; reject <= 1'b0;
      x0_out <= '0; y0_out <= '0; x1_out <= '0; y1_out <= '0;
      iter <= '0; x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0;
      r_xmin <= '0; r_ymin <= '0; r_xmax <= '0; r_ymax <= '0;
      oc_out <= '0; use_p0 <= 1'b0; verdict_acc <= 1'b0;
      is_y_r <= 1'b0; e_r <= '0; quo <= '0; rem <= '0; den_r <= '0;
      q_neg <= 1'b0; div_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          x0 <= x0_in; y0 <= y0_in; x1 <= x1_in; y1 <= y1_in;
          r_xmin <= xmin; r_ymin <= ymin; r_xmax <= xmax; r_ymax <= ymax;
          iter  <= '0;
          state <= S_OUTCODE;
        end
        S_OUTCODE: begin
          if ((oc0 | oc1) == 4'b0000) begin
            verdict_acc <= 1'b1; state <= S_DONE;
          end else if ((oc0 & oc1) != 4'b0000 || iter == IW'(MAX_ITER)) begin
            verdict_acc <= 1'b0; state <= S_DONE;
          end else begin
            oc_out <= (oc0 != 4'b0000) ? oc0 : oc1;
            use_p0 <= (oc0 != 4'b0000);
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          quo     <= num_mag;
          rem     <= '0;
          den_r   <= den_mag;
          q_neg   <= num[N-1] ^ den[COORD_W];
          e_r     <= e_sel;
          is_y_r  <= is_y;
          div_cnt <= '0;
          state   <= S_DIV;
        end
        S_DIV: begin
          rem <= fits ? (rem_sh - {1'b0, den_r}) : rem_sh;
          quo <= {quo[N-2:0], fits};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DCW'(N-1)) state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (use_p0) begin x0 <= nx; y0 <= ny; end
          else        begin x1 <= nx; y1 <= ny; end
          iter  <= iter + 1'b1;
          state <= S_OUTCODE;
        end
        S_DONE: begin
          // First DONE cycle registers the result; out_valid rises after it.
          if (!out_valid) begin
            out_valid <= 1'b1;
            x0_out <= x0; y0_out <= y0; x1_out <= x1; y1_out <= y1;
            accept <= verdict_acc;
            reject <= ~verdict_acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            accept <= 1'b0;
            reject <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_co_su_seq.sv
// Bench for co_su_seq: directed lines against the rectangle (0,0)-(639,479).
// Expected results come from a plain-integer Cohen-Sutherland model and are
// queued in a scoreboard, which a single negedge process checks every cycle
// out_valid is high.
module tb_co_su_seq;

  localparam int W        = 16;
  localparam int MAX_ITER = 4;
  localparam int PASS_LAT = 2*W + 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x0_in = '0, y0_in = '0, x1_in = '0, y1_in = '0;
  logic [W-1:0] xmin = '0, ymin = '0, xmax = '0, ymax = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] x0_out, y0_out, x1_out, y1_out;
  logic         accept, reject;
  logic [2:0]   dbg_state;

  co_su_seq #(.COORD_W(W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
    .xmin(xmin), .ymin(ymin), .xmax(xmax), .ymax(ymax),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_out(x0_out), .y0_out(y0_out), .x1_out(x1_out), .y1_out(y1_out),
    .accept(accept), .reject(reject), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    int x0; int y0; int x1; int y1;
    bit acc; int lat; int hs;
  } exp_t;
  exp_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  bit first_seen = 1'b0;

  localparam int RXMIN = 0, RYMIN = 0, RXMAX = 639, RYMAX = 479;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] oc(input int x, input int y);
    return {y > RYMAX, y < RYMIN, x > RXMAX, x < RXMIN};
  endfunction

  function automatic int t16(input longint v);
    shortint s;
    s = shortint'(v);
    return int'(s);
  endfunction

  task automatic model(input int ax0, ay0, ax1, ay1,
                       output int rx0, ry0, rx1, ry1, output bit acc, output int lat);
    int passes = 0;
    logic [3:0] c0, c1, co;
    int nx, ny;
    longint q;
    acc = 1'b0;
    forever begin
      c0 = oc(ax0, ay0);
      c1 = oc(ax1, ay1);
      if ((c0 | c1) == 4'b0) begin acc = 1'b1; break; end
      if ((c0 & c1) != 4'b0 || passes == MAX_ITER) begin acc = 1'b0; break; end
      co = (c0 != 4'b0) ? c0 : c1;
      if (co[3] || co[2]) begin
        ny = co[3] ? RYMAX : RYMIN;
        q  = (longint'(ax1 - ax0) * longint'(ny - ay0)) / longint'(ay1 - ay0);
        nx = t16(longint'(ax0) + q);
      end else begin
        nx = co[1] ? RXMAX : RXMIN;
        q  = (longint'(ay1 - ay0) * longint'(nx - ax0)) / longint'(ax1 - ax0);
        ny = t16(longint'(ay0) + q);
      end
      if (co == c0) begin ax0 = nx; ay0 = ny; end
      else          begin ax1 = nx; ay1 = ny; end
      passes++;
    end
    rx0 = ax0; ry0 = ay0; rx1 = ax1; ry1 = ay1;
    lat = 2 + passes * PASS_LAT;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("x0_out", int'($signed(x0_out)), exp_q[0].x0);
        check("y0_out", int'($signed(y0_out)), exp_q[0].y0);
        check("x1_out", int'($signed(x1_out)), exp_q[0].x1);
        check("y1_out", int'($signed(y1_out)), exp_q[0].y1);
        check("accept", accept, exp_q[0].acc);
        check("reject", reject, !exp_q[0].acc);
        check("in_ready_busy", in_ready, 0);
        if (!first_seen) begin
          check("latency", cyc - exp_q[0].hs, exp_q[0].lat);
          first_seen = 1'b1;
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int a0, b0, a1, b1, input bit push,
                      input bit pin, input int p0, p1, p2, p3, input bit pacc, input int plat);
    int mx0, my0, mx1, my1, mlat, t;
    bit macc;
    exp_t e;
    model(a0, b0, a1, b1, mx0, my0, mx1, my1, macc, mlat);
    if (pin) begin
      check("model_x0", mx0, p0); check("model_y0", my0, p1);
      check("model_x1", mx1, p2); check("model_y1", my1, p3);
      check("model_acc", macc, pacc); check("model_lat", mlat, plat);
    end
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin check("in_ready_timeout", 0, 1); return; end
    x0_in = W'(a0); y0_in = W'(b0); x1_in = W'(a1); y1_in = W'(b1);
    xmin = W'(RXMIN); ymin = W'(RYMIN); xmax = W'(RXMAX); ymax = W'(RYMAX);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = '{x0: mx0, y0: my0, x1: mx1, y1: my1, acc: macc, lat: mlat, hs: cyc};
    if (push) exp_q.push_back(e);
    // Scramble the inputs while the line is in flight; they must be ignored.
    x0_in = W'($urandom_range(0, 65535)); y0_in = W'($urandom_range(0, 65535));
    x1_in = W'($urandom_range(0, 65535)); y1_in = W'($urandom_range(0, 65535));
    xmin = W'($urandom_range(0, 65535)); ymax = W'($urandom_range(0, 65535));
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_accept", accept, 0);
    check("rst_reject", reject, 0);
    check("rst_x0_out", x0_out, 0);
    check("rst_y1_out", y1_out, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Test-plan vectors with hand-computed results.
    send(10, 10, 100, 200,     1, 1, 10, 10, 100, 200, 1, 2);  wait_drain();
    send(-50, 10, -5, 300,     1, 1, -50, 10, -5, 300, 0, 2);  wait_drain();
    send(100, 100, 700, 100,   1, 1, 100, 100, 639, 100, 1, 39); wait_drain();
    send(-100, -100, 700, 700, 1, 1, 0, 0, 479, 479, 1, 76);   wait_drain();
    send(-7, 3, 9, 10,         1, 1, 0, 6, 9, 10, 1, 39);      wait_drain();
    // Negative quotient truncates toward zero: x = 100 + (-1000/320) = 97.
    send(100, -20, 50, 300,    1, 1, 97, 0, 50, 300, 1, 39);   wait_drain();
    // Corners of the rectangle are inside.
    send(0, 0, 639, 479,       1, 1, 0, 0, 639, 479, 1, 2);    wait_drain();
    // Model-only vectors.
    send(600, -50, 700, 50,    1, 0, 0, 0, 0, 0, 0, 0);        wait_drain();
    send(200, -10, 200, 600,   1, 0, 0, 0, 0, 0, 0, 0);        wait_drain();
    send(-30, 240, 700, 250,   1, 0, 0, 0, 0, 0, 0, 0);        wait_drain();

    // Backpressure: hold the result for 10 cycles; compare process re-checks it.
    @(posedge clk); #1 out_ready = 1'b0;
    send(100, 100, 700, 100, 1, 0, 0, 0, 0, 0, 0, 0);
    begin
      int t = 0;
      while (!out_valid && t < 200) begin @(negedge clk); t++; end
      check("bp_out_valid", out_valid, 1);
      repeat (10) @(negedge clk);
      check("bp_still_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of the divide discards the line.
    send(-100, -100, 700, 700, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_x0_out", x0_out, 0);
    begin
      int t = 0;
      while (t < 100) begin
        @(negedge clk); t++;
        if (out_valid) check("midrst_spurious_valid", out_valid, 0);
      end
    end
    send(10, 10, 100, 200, 1, 1, 10, 10, 100, 200, 1, 2); wait_drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
